// File: rtl/boot_dump_tx.sv
// Reads the instruction memory word by word over the boot bus and streams it out as 8N1 UART:
// header byte, then each word LSB byte first. Define DUMP_CHECKSUM_EN to append a mod-256 byte sum.
module boot_dump_tx #(
  parameter int          CLK_DIV  = 16,
  parameter int          DEPTH    = 1024,
  parameter logic [7:0]  HDR_BYTE = 8'hAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        req,
  input  logic        gnt,
  input  logic        rvalid,
  input  logic        err,
  output logic [31:0] addr,
  input  logic [31:0] rdata,
  output logic        we,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        err_flag
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_REQ, S_WAIT, S_SEND, S_CSUM, S_FIN
  } state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [1:0]        byte_sel_reg, byte_sel_next;
  logic [31:0]       word_reg, word_next;
  logic              err_flag_reg, err_flag_next;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]        sum_reg, sum_next;
`endif

  logic              load;
  logic [7:0]        load_byte;

  logic              tx_reg;
  logic              active_reg;
  logic [8:0]        shift_reg;
  logic [3:0]        bit_cnt_reg;
  logic [DIV_W-1:0]  div_cnt_reg;
  logic              frame_last;

  // High during the final cycle of a stop bit; a load in that cycle chains frames with no gap.
  assign frame_last = active_reg && (bit_cnt_reg == 4'd9) && (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_reg      <= 1'b1;
      active_reg  <= 1'b0;
      shift_reg   <= '1;
      bit_cnt_reg <= '0;
      div_cnt_reg <= '0;
    end else if (load) begin
      tx_reg      <= 1'b0;
      shift_reg   <= {1'b1, load_byte};
      bit_cnt_reg <= '0;
      div_cnt_reg <= '0;
      active_reg  <= 1'b1;
    end else if (active_reg) begin
      if (div_cnt_reg == DIV_LAST) begin
        div_cnt_reg <= '0;
        if (bit_cnt_reg == 4'd9) begin
          active_reg <= 1'b0;
          tx_reg     <= 1'b1;
        end else begin
          tx_reg      <= shift_reg[0];
          shift_reg   <= {1'b1, shift_reg[8:1]};
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      byte_sel_reg <= '0;
      word_reg     <= '0;
      err_flag_reg <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      byte_sel_reg <= byte_sel_next;
      word_reg     <= word_next;
      err_flag_reg <= err_flag_next;
`ifdef DUMP_CHECKSUM_EN
      sum_reg      <= sum_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    byte_sel_next = byte_sel_reg;
    word_next     = word_reg;
    err_flag_next = err_flag_reg;
    load          = 1'b0;
    load_byte     = HDR_BYTE;
`ifdef DUMP_CHECKSUM_EN
    sum_next      = sum_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next    = S_HDR;
          load          = 1'b1;
          load_byte     = HDR_BYTE;
          idx_next      = '0;
          err_flag_next = 1'b0;
`ifdef DUMP_CHECKSUM_EN
          sum_next      = '0;
`endif
        end
      end
      S_HDR: begin
        if (frame_last) state_next = S_REQ;
      end
      S_REQ: begin
        if (gnt) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (rvalid) begin
          if (err) begin
            err_flag_next = 1'b1;
            state_next    = S_IDLE;
          end else begin
            // First byte starts on the very next cycle; the rest follow from the latched word.
            word_next     = rdata;
            byte_sel_next = 2'd0;
            load          = 1'b1;
            load_byte     = rdata[7:0];
            state_next    = S_SEND;
`ifdef DUMP_CHECKSUM_EN
            sum_next      = sum_reg + rdata[7:0] + rdata[15:8] + rdata[23:16] + rdata[31:24];
`endif
          end
        end
      end
      S_SEND: begin
        if (frame_last) begin
          if (byte_sel_reg != 2'd3) begin
            byte_sel_next = byte_sel_reg + 2'd1;
            load          = 1'b1;
            load_byte     = word_reg[{byte_sel_next, 3'b000} +: 8];
          end else if (idx_reg == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
            load       = 1'b1;
            load_byte  = sum_reg;
            state_next = S_CSUM;
`else
            state_next = S_FIN;
`endif
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = S_REQ;
          end
        end
      end
      S_CSUM: begin
        if (frame_last) state_next = S_FIN;
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign req      = (state_reg == S_REQ);
  assign addr     = 32'({idx_reg, 2'b00});
  assign we       = 1'b0;
  assign tx       = tx_reg;
  assign busy     = (state_reg != S_IDLE) && (state_reg != S_FIN);
  assign done     = (state_reg == S_FIN);
  assign err_flag = err_flag_reg;

endmodule

// File: tb/tb_boot_dump_tx.sv
// Self-checking bench for boot_dump_tx: bus responder, UART decoder and a byte-level reference model.
module tb_boot_dump_tx;

  localparam int         CLK_DIV = 4;
  localparam int         DEPTH   = 2;
  localparam logic [7:0] HDR     = 8'hAA;
  localparam int         NONE    = 99;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        req, gnt, rvalid, err, we, tx, busy, done, err_flag;
  logic [31:0] addr, rdata;

  boot_dump_tx #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .HDR_BYTE(HDR)) dut (
    .clk(clk), .rst(rst), .start(start), .req(req), .gnt(gnt), .rvalid(rvalid),
    .err(err), .addr(addr), .rdata(rdata), .we(we), .tx(tx), .busy(busy),
    .done(done), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Memory image and responder configuration
  logic [31:0] mem [DEPTH];
  int          gnt_dly = 0;
  int          rv_dly  = 1;
  int          err_word = NONE;
  bit          noise = 1'b0;
  int          req_cyc_q[$];
  logic [31:0] addr_q[$];
  int          stable_bad, we_bad;

  initial begin
    logic [31:0] a;
    int          w;
    gnt = 1'b0; rvalid = 1'b0; err = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      if (req === 1'b1 && !rst) begin
        a = addr;
        req_cyc_q.push_back(cyc);
        addr_q.push_back(a);
        if (we !== 1'b0) we_bad++;
        gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
        for (int i = 0; i < gnt_dly; i++) begin
          @(negedge clk);
          if (req !== 1'b1 || addr !== a) stable_bad++;
        end
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        if (req !== 1'b0) stable_bad++;
        for (int i = 1; i < rv_dly; i++) @(negedge clk);
        w = int'(a >> 2);
        rvalid = 1'b1;
        err    = (w == err_word);
        rdata  = (w < DEPTH) ? mem[w] : 32'hDEAD_BEEF;
        @(negedge clk);
        rvalid = 1'b0; err = 1'b0; rdata = $urandom;
      end else if (noise) begin
        gnt    = 1'($urandom_range(0, 1));
        rvalid = 1'($urandom_range(0, 1));
        err    = 1'($urandom_range(0, 1));
        rdata  = $urandom;
      end else begin
        gnt = 1'b0; rvalid = 1'b0; err = 1'b0;
      end
    end
  end

  // UART decoder: every bit must hold for exactly CLK_DIV samples
  logic [7:0] rx_q[$];
  int         end_q[$];
  int         done_cnt, done_cyc, frame_bad;
  logic       done_busy;

  initial begin
    bit         active;
    int         s;
    logic [9:0] bits;
    active = 1'b0; s = 0; bits = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
      end else begin
        if (done === 1'b1) begin
          done_cnt++;
          done_cyc  = cyc;
          done_busy = busy;
        end
        if (!active && tx === 1'b0) begin
          active = 1'b1;
          s = 0;
        end
        if (active) begin
          if (s % CLK_DIV == 0) bits[s / CLK_DIV] = tx;
          else if (tx !== bits[s / CLK_DIV]) frame_bad++;
          if (s == 10 * CLK_DIV - 1) begin
            if (bits[9] !== 1'b1) frame_bad++;
            rx_q.push_back(bits[8:1]);
            end_q.push_back(cyc);
            active = 1'b0;
          end
          s++;
        end
      end
    end
  end

  typedef struct {
    int          gnt_dly;
    int          rv_dly;
    int          err_word;
    bit          noise;
    bit          extra_start;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          exp_err;
    int          exp_done;
  } vec_t;

  task automatic clear_logs();
    rx_q.delete(); end_q.delete(); req_cyc_q.delete(); addr_q.delete();
    done_cnt = 0; done_cyc = -1; done_busy = 1'bx;
    stable_bad = 0; we_bad = 0; frame_bad = 0;
  endtask

  task automatic run_dump(input vec_t v, input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] sum;
    int         nw, nreq, n, t;
    mem[0] = v.w0; mem[1] = v.w1;
    gnt_dly = v.gnt_dly; rv_dly = v.rv_dly; err_word = v.err_word; noise = v.noise;
    clear_logs();
    // Reference: header, then every word fetched before the failing one, LSB byte first
    nw   = (v.err_word < DEPTH) ? v.err_word : DEPTH;
    nreq = (v.err_word < DEPTH) ? nw + 1 : DEPTH;
    sum  = 8'h00;
    exp_q.push_back(HDR);
    for (int i = 0; i < nw; i++)
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(mem[i][8*b +: 8]);
        sum = sum + mem[i][8*b +: 8];
      end
`ifdef DUMP_CHECKSUM_EN
    if (nw == DEPTH) exp_q.push_back(sum);
`endif
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check({tag, " busy_at_start"}, 32'(busy), 32'd1);
    check({tag, " tx_start_bit"}, 32'(tx), 32'd0);
    t = 0;
    while (busy === 1'b1 && t < 3000) begin
      @(negedge clk);
      t++;
      start = (v.extra_start && t == 20);
    end
    start = 1'b0;
    check({tag, " finished_in_time"}, 32'(t < 3000), 32'd1);
    repeat (12) @(negedge clk);
    check({tag, " done_pulses"}, 32'(done_cnt), 32'(v.exp_done));
    check({tag, " err_flag"}, 32'(err_flag), 32'(v.exp_err));
    check({tag, " byte_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    check({tag, " req_count"}, 32'(addr_q.size()), 32'(nreq));
    for (int k = 0; k < addr_q.size() && k < nreq; k++) begin
      check($sformatf("%s addr%0d", tag, k), addr_q[k], 32'(4 * k));
      if (end_q.size() > 4 * k)
        check($sformatf("%s req%0d_cycle", tag, k), 32'(req_cyc_q[k]), 32'(end_q[4 * k] + 1));
    end
    if (v.exp_done == 1 && end_q.size() > 0) begin
      check({tag, " done_cycle"}, 32'(done_cyc), 32'(end_q[end_q.size() - 1] + 1));
      check({tag, " busy_at_done"}, 32'(done_busy), 32'd0);
    end
    check({tag, " req_addr_stable"}, 32'(stable_bad), 32'd0);
    check({tag, " we_zero"}, 32'(we_bad), 32'd0);
    check({tag, " frame_shape"}, 32'(frame_bad), 32'd0);
    $display("dump %s: words=%0d bytes=%0d sum=%02h err_flag=%0d done=%0d",
             tag, nw, rx_q.size(), sum, err_flag, done_cnt);
  endtask

  vec_t vecs[5];
  vec_t rv;
  int   t;

  initial begin
    vecs[0] = '{0, 1, NONE, 1'b0, 1'b0, 32'h12345678, 32'hCAFEF00D, 1'b0, 1};
    vecs[1] = '{3, 2, NONE, 1'b0, 1'b0, 32'h12345678, 32'hCAFEF00D, 1'b0, 1};
    vecs[2] = '{0, 1, 1,    1'b0, 1'b0, 32'h12345678, 32'hCAFEF00D, 1'b1, 0};
    vecs[3] = '{1, 1, NONE, 1'b1, 1'b1, 32'h000000FF, 32'h80000001, 1'b0, 1};
    vecs[4] = '{2, 3, 0,    1'b1, 1'b0, 32'hA5A55A5A, 32'h0F0F0F0F, 1'b1, 0};

    // Reset with start held high: reset must win
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset req", 32'(req), 32'd0);
    check("reset addr", addr, 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err_flag", 32'(err_flag), 32'd0);
    check("reset we", 32'(we), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("start_under_reset ignored", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) run_dump(vecs[i], $sformatf("vec%0d", i));

    // Reset clears a sticky error flag left by vec4
    rst = 1'b1;
    #1 check("rst clears err_flag", 32'(err_flag), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Reset mid-frame forces the line high at once
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    t = 0;
    while (!(tx === 1'b0 && t >= 6) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("midframe tx low before rst", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    check("midframe rst tx", 32'(tx), 32'd1);
    check("midframe rst busy", 32'(busy), 32'd0);
    check("midframe rst req", 32'(req), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_dump(vecs[0], "after_rst");

    // Randomized dumps against the reference model
    for (int r = 0; r < 8; r++) begin
      int sel;
      sel = $urandom_range(0, 5);
      rv.gnt_dly     = $urandom_range(0, 4);
      rv.rv_dly      = $urandom_range(1, 4);
      rv.err_word    = (sel < DEPTH) ? sel : NONE;
      rv.noise       = 1'($urandom_range(0, 1));
      rv.extra_start = 1'($urandom_range(0, 1));
      rv.w0          = $urandom;
      rv.w1          = $urandom;
      rv.exp_err     = (rv.err_word < DEPTH);
      rv.exp_done    = (rv.err_word < DEPTH) ? 0 : 1;
      run_dump(rv, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
